// File: rtl/axi_regfile_slave.sv
// AXI4 slave exposing DEPTH x 32-bit control/status registers to fabric logic.
// Supports WSTRB byte enables, FIXED/INCR bursts and ID echo. Read and write channels are independent.
module axi_regfile_slave #(
  parameter  int ID_WIDTH   = 4,
  parameter  int DEPTH      = 16,
  parameter  int ADDR_WIDTH = 32,
  localparam int IDX_W      = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rstn,
  // write address
  input  logic [ID_WIDTH-1:0]   i_awid,
  input  logic [ADDR_WIDTH-1:0] i_awaddr,
  input  logic [7:0]            i_awlen,
  input  logic [2:0]            i_awsize,
  input  logic [1:0]            i_awburst,
  input  logic                  i_awvalid,
  output logic                  o_awready,
  // write data
  input  logic [31:0]           i_wdata,
  input  logic [3:0]            i_wstrb,
  input  logic                  i_wlast,
  input  logic                  i_wvalid,
  output logic                  o_wready,
  // write response
  output logic [ID_WIDTH-1:0]   o_bid,
  output logic [1:0]            o_bresp,
  output logic                  o_bvalid,
  input  logic                  i_bready,
  // read address
  input  logic [ID_WIDTH-1:0]   i_arid,
  input  logic [ADDR_WIDTH-1:0] i_araddr,
  input  logic [7:0]            i_arlen,
  input  logic [2:0]            i_arsize,
  input  logic [1:0]            i_arburst,
  input  logic                  i_arvalid,
  output logic                  o_arready,
  // read data
  output logic [ID_WIDTH-1:0]   o_rid,
  output logic [31:0]           o_rdata,
  output logic [1:0]            o_rresp,
  output logic                  o_rlast,
  output logic                  o_rvalid,
  input  logic                  i_rready,
  // fabric side
  output logic [DEPTH*32-1:0]   regs_flat,
  output logic [DEPTH-1:0]      wr_pulse
);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_FIXED = 2'b00;

  // Only 32-bit beats of FIXED or INCR bursts are served; everything else is answered SLVERR.
  function automatic logic burst_err(input logic [2:0] size, input logic [1:0] burst);
    return (size != 3'b010) || burst[1];
  endfunction

  logic [31:0]          r_regs [DEPTH];
  logic [DEPTH-1:0]     r_wr_pulse;

  w_state_e             r_wstate, w_wstate_nxt;
  logic                 r_awready, r_wready, r_bvalid;
  logic [ID_WIDTH-1:0]  r_wid, r_bid;
  logic [1:0]           r_bresp;
  logic [IDX_W-1:0]     r_widx;
  logic [7:0]           r_wlen, r_wcnt;
  logic                 r_wfixed, r_werr, r_wlast_err;

  r_state_e             r_rstate, w_rstate_nxt;
  logic                 r_arready, r_rvalid, r_rlast;
  logic [ID_WIDTH-1:0]  r_rid;
  logic [31:0]          r_rdata;
  logic [1:0]           r_rresp;
  logic [IDX_W-1:0]     r_ridx;
  logic [7:0]           r_rlen, r_rcnt;
  logic                 r_rfixed, r_rerr;

  logic                 w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;
  logic                 w_wbeat_last, w_wlast_bad, w_ar_err;
  logic [IDX_W-1:0]     w_ar_idx;
  logic                 w_unused;

  assign w_aw_hs      = i_awvalid & r_awready;
  assign w_w_hs       = i_wvalid  & r_wready;
  assign w_b_hs       = r_bvalid  & i_bready;
  assign w_ar_hs      = i_arvalid & r_arready;
  assign w_r_hs       = r_rvalid  & i_rready;
  assign w_wbeat_last = (r_wcnt == r_wlen);
  assign w_wlast_bad  = (i_wlast != w_wbeat_last);
  assign w_ar_idx     = i_araddr[2+:IDX_W];
  assign w_ar_err     = burst_err(i_arsize, i_arburst);
  assign w_unused     = ^{i_awaddr[1:0], i_awaddr[ADDR_WIDTH-1:IDX_W+2],
                          i_araddr[1:0], i_araddr[ADDR_WIDTH-1:IDX_W+2]};

  // ---------------- write channel ----------------
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    w_wstate_nxt = r_wstate;
    unique case (r_wstate)
      W_IDLE:  if (w_aw_hs)                 w_wstate_nxt = W_DATA;
      W_DATA:  if (w_w_hs && w_wbeat_last)  w_wstate_nxt = W_RESP;
      W_RESP:  if (w_b_hs)                  w_wstate_nxt = W_IDLE;
      default:                              w_wstate_nxt = W_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wstate    <= W_IDLE;
      r_awready   <= 1'b0;
      r_wready    <= 1'b0;
      r_bvalid    <= 1'b0;
      r_bid       <= '0;
      r_bresp     <= RESP_OKAY;
      r_wid       <= '0;
      r_widx      <= '0;
      r_wlen      <= '0;
      r_wcnt      <= '0;
      r_wfixed    <= 1'b0;
      r_werr      <= 1'b0;
      r_wlast_err <= 1'b0;
    end else begin
      r_wstate  <= w_wstate_nxt;
      r_awready <= (w_wstate_nxt == W_IDLE);
      r_wready  <= (w_wstate_nxt == W_DATA);
      r_bvalid  <= (w_wstate_nxt == W_RESP);
      if (w_aw_hs) begin
        r_wid       <= i_awid;
        r_widx      <= i_awaddr[2+:IDX_W];
        r_wlen      <= i_awlen;
        r_wcnt      <= '0;
        r_wfixed    <= (i_awburst == BURST_FIXED);
        r_werr      <= burst_err(i_awsize, i_awburst);
        r_wlast_err <= 1'b0;
      end
      if (w_w_hs) begin
        r_wcnt <= r_wcnt + 8'd1;
        if (!r_wfixed)   r_widx      <= r_widx + 1'b1;
        if (w_wlast_bad) r_wlast_err <= 1'b1;
        // The beat count, not WLAST, closes the burst; a WLAST mismatch only taints the response.
        if (w_wbeat_last) begin
          r_bid   <= r_wid;
          r_bresp <= (r_werr || r_wlast_err || w_wlast_bad) ? RESP_SLVERR : RESP_OKAY;
        end
      end
    end
  end

  // ---------------- register file ----------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      // NOTE: this array is reset on purpose: its contents drive fabric control logic directly.
      for (int i = 0; i < DEPTH; i++) r_regs[i] <= '0;
      r_wr_pulse <= '0;
    end else begin
      r_wr_pulse <= '0;
      if (w_w_hs && !r_werr) begin
        for (int b = 0; b < 4; b++) begin
          if (i_wstrb[b]) r_regs[r_widx][8*b+:8] <= i_wdata[8*b+:8];
        end
        if (|i_wstrb) r_wr_pulse[r_widx] <= 1'b1;
      end
    end
  end

  always_comb begin
    regs_flat = '0;
    for (int i = 0; i < DEPTH; i++) regs_flat[32*i+:32] = r_regs[i];
  end

  // ---------------- read channel ----------------
  always_comb begin
    w_rstate_nxt = r_rstate;
    unique case (r_rstate)
      R_IDLE:  if (w_ar_hs)            w_rstate_nxt = R_DATA;
      R_DATA:  if (w_r_hs && r_rlast)  w_rstate_nxt = R_IDLE;
      default:                         w_rstate_nxt = R_IDLE;
    endcase
  end

  // r_ridx always points at the register of the beat after the one being presented.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rstate  <= R_IDLE;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rlast   <= 1'b0;
      r_rresp   <= RESP_OKAY;
      r_rdata   <= '0;
      r_rid     <= '0;
      r_ridx    <= '0;
      r_rlen    <= '0;
      r_rcnt    <= '0;
      r_rfixed  <= 1'b0;
      r_rerr    <= 1'b0;
    end else begin
      r_rstate  <= w_rstate_nxt;
      r_arready <= (w_rstate_nxt == R_IDLE);
      r_rvalid  <= (w_rstate_nxt == R_DATA);
      if (w_ar_hs) begin
        r_rid    <= i_arid;
        r_rlen   <= i_arlen;
        r_rcnt   <= '0;
        r_rfixed <= (i_arburst == BURST_FIXED);
        r_rerr   <= w_ar_err;
        r_ridx   <= (i_arburst == BURST_FIXED) ? w_ar_idx : w_ar_idx + 1'b1;
        r_rdata  <= w_ar_err ? 32'd0 : r_regs[w_ar_idx];
        r_rresp  <= w_ar_err ? RESP_SLVERR : RESP_OKAY;
        r_rlast  <= (i_arlen == 8'd0);
      end else if (w_r_hs && !r_rlast) begin
        r_rcnt  <= r_rcnt + 8'd1;
        r_ridx  <= r_rfixed ? r_ridx : r_ridx + 1'b1;
        r_rdata <= r_rerr ? 32'd0 : r_regs[r_ridx];
        r_rlast <= ((r_rcnt + 8'd1) == r_rlen);
      end
    end
  end

  assign o_awready = r_awready;
  assign o_wready  = r_wready;
  assign o_bvalid  = r_bvalid;
  assign o_bid     = r_bid;
  assign o_bresp   = r_bresp;
  assign o_arready = r_arready;
  assign o_rvalid  = r_rvalid;
  assign o_rid     = r_rid;
  assign o_rdata   = r_rdata;
  assign o_rresp   = r_rresp;
  assign o_rlast   = r_rlast;
  assign wr_pulse  = r_wr_pulse;

endmodule

// File: tb/tb_axi_regfile_slave.sv
// Self-checking bench for axi_regfile_slave: a transaction-level register model checked every
// cycle at the falling edge, directed scenarios with literal expectations, and a random phase.
module tb_axi_regfile_slave;
  localparam int ID_WIDTH = 4;
  localparam int DEPTH    = 16;
  localparam int TMO      = 200;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic [ID_WIDTH-1:0] i_awid = '0, i_arid = '0;
  logic [31:0]         i_awaddr = '0, i_araddr = '0, i_wdata = '0;
  logic [7:0]          i_awlen = '0, i_arlen = '0;
  logic [2:0]          i_awsize = 3'd2, i_arsize = 3'd2;
  logic [1:0]          i_awburst = 2'd1, i_arburst = 2'd1;
  logic                i_awvalid = 1'b0, i_wlast = 1'b0, i_wvalid = 1'b0, i_bready = 1'b0;
  logic                i_arvalid = 1'b0, i_rready = 1'b0;
  logic [3:0]          i_wstrb = '0;
  logic                o_awready, o_wready, o_bvalid, o_arready, o_rvalid, o_rlast;
  logic [ID_WIDTH-1:0] o_bid, o_rid;
  logic [1:0]          o_bresp, o_rresp;
  logic [31:0]         o_rdata;
  logic [DEPTH*32-1:0] regs_flat;
  logic [DEPTH-1:0]    wr_pulse;

  axi_regfile_slave #(.ID_WIDTH(ID_WIDTH), .DEPTH(DEPTH), .ADDR_WIDTH(32)) dut (
    .clk(clk), .rstn(rstn),
    .i_awid(i_awid), .i_awaddr(i_awaddr), .i_awlen(i_awlen), .i_awsize(i_awsize),
    .i_awburst(i_awburst), .i_awvalid(i_awvalid), .o_awready(o_awready),
    .i_wdata(i_wdata), .i_wstrb(i_wstrb), .i_wlast(i_wlast), .i_wvalid(i_wvalid), .o_wready(o_wready),
    .o_bid(o_bid), .o_bresp(o_bresp), .o_bvalid(o_bvalid), .i_bready(i_bready),
    .i_arid(i_arid), .i_araddr(i_araddr), .i_arlen(i_arlen), .i_arsize(i_arsize),
    .i_arburst(i_arburst), .i_arvalid(i_arvalid), .o_arready(o_arready),
    .o_rid(o_rid), .o_rdata(o_rdata), .o_rresp(o_rresp), .o_rlast(o_rlast), .o_rvalid(o_rvalid),
    .i_rready(i_rready), .regs_flat(regs_flat), .wr_pulse(wr_pulse)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0]      m_regs [DEPTH];
  logic [DEPTH-1:0] m_pulse;
  bit               m_seen_edge;
  int               m_wphase;          // 0 waiting for address, 1 taking data, 2 holding response
  logic [3:0]       m_wid;
  int               m_wbase, m_wlen, m_wbeat;
  bit               m_wfixed, m_werr, m_wmism;
  logic [1:0]       m_bresp;
  bit               m_ractive;
  logic [3:0]       m_rid;
  int               m_rbase, m_rlen, m_rbeat;
  bit               m_rfixed, m_rerr;
  logic [31:0]      m_rdata;
  int               pulse_cnt [DEPTH];

  function automatic int beat_idx(input int base, input int k, input bit fixed);
    return fixed ? base : (base + k) % DEPTH;
  endfunction

  function automatic bit bad_burst(input logic [2:0] size, input logic [1:0] burst);
    return (size != 3'd2) || (burst > 2'd1);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_regs[i] = '0;
    m_pulse = '0; m_seen_edge = 0; m_wphase = 0; m_ractive = 0; m_bresp = 2'd0;
  endtask

  task automatic compare_outputs();
    for (int i = 0; i < DEPTH; i++) begin
      check($sformatf("reg%0d", i), regs_flat[32*i+:32], m_regs[i]);
      if (wr_pulse[i]) pulse_cnt[i]++;
    end
    check("wr_pulse", wr_pulse, m_pulse);
    check("awready", o_awready, m_wphase == 0 && m_seen_edge);
    check("wready", o_wready, m_wphase == 1);
    check("bvalid", o_bvalid, m_wphase == 2);
    if (m_wphase == 2) begin
      check("bid", o_bid, m_wid);
      check("bresp", o_bresp, m_bresp);
    end
    check("arready", o_arready, !m_ractive && m_seen_edge);
    check("rvalid", o_rvalid, m_ractive);
    if (m_ractive) begin
      check("rid", o_rid, m_rid);
      check("rdata", o_rdata, m_rdata);
      check("rresp", o_rresp, m_rerr ? 2'd2 : 2'd0);
      check("rlast", o_rlast, m_rbeat == m_rlen);
    end
  endtask

  // Moves the model across the coming rising edge using the handshakes visible now.
  task automatic advance_model();
    bit aw_hs, w_hs, b_hs, ar_hs, r_hs;
    int idx;
    aw_hs = i_awvalid && o_awready;
    w_hs  = i_wvalid && o_wready;
    b_hs  = o_bvalid && i_bready;
    ar_hs = i_arvalid && o_arready;
    r_hs  = o_rvalid && i_rready;
    m_pulse = '0;
    m_seen_edge = 1;
    // reads load first: a write landing on the same edge is not yet visible
    if (!m_ractive && ar_hs) begin
      m_ractive = 1; m_rid = i_arid; m_rbase = int'((i_araddr >> 2) % DEPTH);
      m_rlen = int'(i_arlen); m_rfixed = (i_arburst == 2'd0); m_rerr = bad_burst(i_arsize, i_arburst);
      m_rbeat = 0; m_rdata = m_rerr ? 32'd0 : m_regs[m_rbase];
    end else if (m_ractive && r_hs) begin
      if (m_rbeat == m_rlen) m_ractive = 0;
      else begin
        m_rbeat++;
        m_rdata = m_rerr ? 32'd0 : m_regs[beat_idx(m_rbase, m_rbeat, m_rfixed)];
      end
    end
    case (m_wphase)
      0: if (aw_hs) begin
        m_wid = i_awid; m_wbase = int'((i_awaddr >> 2) % DEPTH); m_wlen = int'(i_awlen);
        m_wfixed = (i_awburst == 2'd0); m_werr = bad_burst(i_awsize, i_awburst);
        m_wbeat = 0; m_wmism = 0; m_wphase = 1;
      end
      1: if (w_hs) begin
        idx = beat_idx(m_wbase, m_wbeat, m_wfixed);
        if (!m_werr) begin
          for (int b = 0; b < 4; b++) if (i_wstrb[b]) m_regs[idx][8*b+:8] = i_wdata[8*b+:8];
          if (i_wstrb != 4'd0) m_pulse[idx] = 1'b1;
        end
        if (i_wlast != (m_wbeat == m_wlen)) m_wmism = 1;
        if (m_wbeat == m_wlen) begin
          m_bresp = (m_werr || m_wmism) ? 2'd2 : 2'd0;
          m_wphase = 2;
        end else m_wbeat++;
      end
      default: if (b_hs) m_wphase = 0;
    endcase
  endtask

  initial begin : compare_proc
    forever begin
      @(negedge clk);
      if (!rstn) begin
        model_reset();
        compare_outputs();
        check("rst_rlast", o_rlast, 1'b0);
        check("rst_rresp", o_rresp, 2'd0);
        check("rst_bresp", o_bresp, 2'd0);
      end else begin
        compare_outputs();
        advance_model();
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [31:0] wbuf_data [16];
  logic [3:0]  wbuf_strb [16];
  logic [31:0] rcap_data [16];
  logic [1:0]  rcap_resp [16];
  logic        rcap_last [16];
  logic [3:0]  cap_bid;
  logic [1:0]  cap_bresp;
  int          rlat;

  function automatic int pulse_total();
    int s = 0;
    for (int i = 0; i < DEPTH; i++) s += pulse_cnt[i];
    return s;
  endfunction

  task automatic clear_pulses();
    for (int i = 0; i < DEPTH; i++) pulse_cnt[i] = 0;
  endtask

  task automatic wait_hs(input int ch, input string name);
    bit hs = 0;
    for (int t = 0; t < TMO && !hs; t++) begin
      @(negedge clk);
      case (ch)
        0: hs = o_awready;
        1: hs = o_wready;
        2: hs = o_bvalid;
        default: hs = o_arready;
      endcase
      if (hs && ch == 2) begin cap_bid = o_bid; cap_bresp = o_bresp; end
      @(posedge clk); #1;
    end
    if (!hs) begin
      n_checks++; n_errors++;
      $display("FAIL %s_timeout: no handshake within %0d cycles", name, TMO);
    end
  endtask

  task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input int len,
                          input logic [2:0] size, input logic [1:0] burst, input int bad_beat,
                          input int b_delay, input bit gaps);
    @(posedge clk); #1;
    i_awid = id; i_awaddr = addr; i_awlen = 8'(len); i_awsize = size; i_awburst = burst;
    i_awvalid = 1'b1;
    wait_hs(0, "aw");
    i_awvalid = 1'b0;
    for (int k = 0; k <= len; k++) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      i_wdata = wbuf_data[k]; i_wstrb = wbuf_strb[k];
      i_wlast = (k == len) ^ (k == bad_beat); i_wvalid = 1'b1;
      wait_hs(1, "w");
      i_wvalid = 1'b0; i_wlast = 1'b0;
    end
    repeat (b_delay) begin @(posedge clk); #1; end
    i_bready = 1'b1;
    wait_hs(2, "b");
    i_bready = 1'b0;
  endtask

  // mode: 0 RREADY always high, 1 toggling 1/0, 2 random
  task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input int len,
                         input logic [2:0] size, input logic [1:0] burst, input int mode);
    int k = 0;
    int t = 0;
    bit tog = 1;
    @(posedge clk); #1;
    i_arid = id; i_araddr = addr; i_arlen = 8'(len); i_arsize = size; i_arburst = burst;
    i_arvalid = 1'b1;
    wait_hs(3, "ar");
    i_arvalid = 1'b0;
    rlat = -1;
    while (k <= len && t < TMO) begin
      i_rready = (mode == 0) ? 1'b1 : (mode == 1) ? tog : 1'($urandom_range(0, 1));
      tog = !tog;
      @(negedge clk);
      if (o_rvalid && rlat < 0) rlat = t + 1;
      if (o_rvalid && i_rready) begin
        rcap_data[k] = o_rdata; rcap_resp[k] = o_rresp; rcap_last[k] = o_rlast; k++;
      end
      @(posedge clk); #1; t++;
    end
    i_rready = 1'b0;
    if (k <= len) begin
      n_checks++; n_errors++;
      $display("FAIL r_timeout: %0d of %0d beats received", k, len + 1);
    end
  endtask

  initial begin : watchdog
    #1ms;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    clear_pulses();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_regs_zero", regs_flat, '0);
    @(posedge clk); #1;
    rstn = 1'b1;
    @(negedge clk);
    check("awready_before_first_edge", o_awready, 1'b0);
    @(negedge clk);
    check("awready_after_first_edge", o_awready, 1'b1);
    check("arready_after_first_edge", o_arready, 1'b1);

    // single write then read of index 2
    wbuf_data[0] = 32'hDEADBEEF; wbuf_strb[0] = 4'hF;
    do_write(4'd3, 32'h08, 0, 3'd2, 2'd1, -1, 0, 1'b0);
    check("t1_bid", cap_bid, 4'd3);
    check("t1_bresp", cap_bresp, 2'd0);
    check("t1_reg2", regs_flat[95:64], 32'hDEADBEEF);
    check("t1_pulse2", pulse_cnt[2], 1);
    check("t1_pulse_total", pulse_total(), 1);
    do_read(4'd5, 32'h08, 0, 3'd2, 2'd1, 0);
    check("t1_rdata", rcap_data[0], 32'hDEADBEEF);
    check("t1_rlast", rcap_last[0], 1'b1);
    check("t1_ar_to_rvalid", rlat, 1);

    // INCR burst wrapping past the top index
    for (int k = 0; k < 4; k++) begin wbuf_data[k] = 32'(k + 1); wbuf_strb[k] = 4'hF; end
    do_write(4'd1, 32'h38, 3, 3'd2, 2'd1, -1, 0, 1'b0);
    check("t2_reg14", regs_flat[32*14+:32], 32'd1);
    check("t2_reg15", regs_flat[32*15+:32], 32'd2);
    check("t2_reg0", regs_flat[31:0], 32'd3);
    check("t2_reg1", regs_flat[63:32], 32'd4);
    do_read(4'd2, 32'h38, 3, 3'd2, 2'd1, 1);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("t2_rdata%0d", k), rcap_data[k], 32'(k + 1));
      check($sformatf("t2_rlast%0d", k), rcap_last[k], k == 3);
    end

    // byte strobes
    wbuf_data[0] = 32'h11223344; wbuf_strb[0] = 4'hF;
    do_write(4'd0, 32'h14, 0, 3'd2, 2'd1, -1, 0, 1'b0);
    wbuf_data[0] = 32'hAABBCCDD; wbuf_strb[0] = 4'b0101;
    do_write(4'd0, 32'h14, 0, 3'd2, 2'd1, -1, 0, 1'b0);
    check("t3_reg5", regs_flat[32*5+:32], 32'h11BB33DD);

    // FIXED burst, WRAP error write, SIZE error read
    clear_pulses();
    for (int k = 0; k < 3; k++) begin wbuf_data[k] = 32'(k + 7); wbuf_strb[k] = 4'hF; end
    do_write(4'd4, 32'h10, 2, 3'd2, 2'd0, -1, 0, 1'b0);
    check("t4_reg4", regs_flat[32*4+:32], 32'd9);
    check("t4_pulse4", pulse_cnt[4], 3);
    clear_pulses();
    wbuf_data[0] = 32'h12345678; wbuf_strb[0] = 4'hF;
    do_write(4'd6, 32'h1C, 0, 3'd2, 2'd2, -1, 0, 1'b0);
    check("t4_wrap_bresp", cap_bresp, 2'd2);
    check("t4_wrap_reg7", regs_flat[32*7+:32], 32'd0);
    check("t4_wrap_pulses", pulse_total(), 0);
    do_read(4'd7, 32'h38, 1, 3'd0, 2'd1, 0);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("t4_size_rdata%0d", k), rcap_data[k], 32'd0);
      check($sformatf("t4_size_rresp%0d", k), rcap_resp[k], 2'd2);
    end

    // early WLAST with a stalled response channel
    for (int k = 0; k < 3; k++) begin wbuf_data[k] = 32'hA0 + 32'(k); wbuf_strb[k] = 4'hF; end
    do_write(4'd9, 32'h24, 2, 3'd2, 2'd1, 1, 5, 1'b0);
    check("t5_bid", cap_bid, 4'd9);
    check("t5_bresp", cap_bresp, 2'd2);
    check("t5_reg11", regs_flat[32*11+:32], 32'hA2);

    // random concurrent traffic
    for (int it = 0; it < 80; it++) begin
      logic [3:0]  wid, rid;
      logic [31:0] wa, ra;
      logic [2:0]  wsz, rsz;
      logic [1:0]  wb, rb;
      int          wl, rl, bad, bd, rm;
      bit          do_w, do_r;
      wid = 4'($urandom); rid = 4'($urandom); wa = $urandom; ra = $urandom;
      wl = $urandom_range(0, 5); rl = $urandom_range(0, 5);
      wb = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
      rb = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
      wsz = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 1)) : 3'd2;
      rsz = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 1)) : 3'd2;
      bad = ($urandom_range(0, 7) == 0) ? $urandom_range(0, wl) : -1;
      bd = $urandom_range(0, 3); rm = $urandom_range(0, 2);
      do_w = ($urandom_range(0, 3) != 0); do_r = ($urandom_range(0, 3) != 0);
      for (int k = 0; k <= wl; k++) begin wbuf_data[k] = $urandom; wbuf_strb[k] = 4'($urandom); end
      fork
        begin if (do_w) do_write(wid, wa, wl, wsz, wb, bad, bd, 1'b1); end
        begin if (do_r) do_read(rid, ra, rl, rsz, rb, rm); end
      join
    end

    // reset in the middle of a read burst
    @(posedge clk); #1;
    i_arid = 4'd6; i_araddr = 32'h0; i_arlen = 8'd7; i_arsize = 3'd2; i_arburst = 2'd1;
    i_arvalid = 1'b1; i_rready = 1'b1;
    wait_hs(3, "t7_ar");
    i_arvalid = 1'b0;
    @(posedge clk); #1;
    check("t7_rvalid_beat1", o_rvalid, 1'b1);
    rstn = 1'b0;
    #1;
    check("t7_rvalid_async", o_rvalid, 1'b0);
    check("t7_regs_clear", regs_flat, '0);
    i_rready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    do_read(4'd1, 32'h0, 0, 3'd2, 2'd1, 0);
    check("t7_rdata", rcap_data[0], 32'd0);
    check("t7_rresp", rcap_resp[0], 2'd0);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/axi_regfile_slave.md
Name: axi_regfile_slave

Overview:
- AXI4 slave hung on one AXI_S[n] port of the bus interconnect; the interconnect delivers transactions already address-decoded to this slave.
- Implements DEPTH x 32-bit control/status registers with WSTRB byte enables, FIXED/INCR bursts and ID echo.
- Exposes register contents and per-register write strobes to fabric logic (lab control registers).

Parameters:
- ID_WIDTH, 4, AXI ID width; equals M_ID+M_WIDTH of the interconnect.
- DEPTH, 16, number of 32-bit registers; power of two, 2..256.
- IDX_W, $clog2(DEPTH), register index width (derived, not overridden).

Ports:
- clk  input  1  bus clock; all logic on the rising edge
- rstn  input  1  asynchronous active-low reset
- AXI_S  interface  AXI_INF.SYNC_S  slave side; fields used: AW{ID,ADDR,LEN,SIZE,BURST,VALID,READY}, W{DATA,STRB,LAST,VALID,READY}, B{ID,RESP,VALID,READY}, AR{ID,ADDR,LEN,SIZE,BURST,VALID,READY}, R{ID,DATA,RESP,LAST,VALID,READY}
- regs_flat  output  DEPTH*32  register contents; register i at [32*i+:32]
- wr_pulse  output  DEPTH  one-cycle strobe when register i is written (any strobe bit)

Behaviour:
- Reset, async on rstn low: all registers 0; AWREADY, WREADY, BVALID, ARREADY, RVALID, RLAST = 0; BRESP/RRESP = 0; wr_pulse = 0; both FSMs to IDLE. AWREADY/ARREADY go 1 on the first clock edge after rstn release. Reset mid-burst abandons the burst, no response.
- Index = ADDR[2+:IDX_W]; upper address bits ignored. INCR: index+1 per beat, wraps modulo DEPTH. FIXED: index constant.
- Error: BURST==WRAP(2'b10) or reserved (2'b11), or SIZE!=3'b010 -> SLVERR (2'b10) for the whole burst; writes dropped, read data 0. Otherwise OKAY.
- Write FSM W_IDLE -> W_DATA -> W_RESP -> W_IDLE:
  - W_IDLE: AWREADY=1; on AW handshake latch ID, index, LEN, BURST, error flag; AWREADY->0, WREADY->1 next cycle.
  - W_DATA: each W handshake writes bytes where WSTRB[b]=1 (unless error), wr_pulse[index]=1 the following cycle. Beat counter 0..LEN. The beat with count==LEN ends the burst: WREADY->0, BVALID->1 next cycle. WLAST mismatch (WLAST=1 before count==LEN or 0 at count==LEN) -> BRESP SLVERR; beat count still governs termination.
  - W_RESP: BVALID held with BID and BRESP until BREADY; then W_IDLE, AWREADY=1 next cycle.
- Read FSM R_IDLE -> R_DATA -> R_IDLE:
  - R_IDLE: ARREADY=1; on AR handshake at cycle N, RVALID=1 at N+1 with beat 0, RID=ARID, RLAST=(LEN==0).
  - R_DATA: RDATA/RRESP/RLAST held stable while RVALID&&!RREADY. On handshake, next beat is presented the following cycle (full throughput with RREADY=1). After last-beat handshake: RVALID->0, R_IDLE, ARREADY=1 next cycle.
- Read and write FSMs are independent and run concurrently. Same-register collision: RDATA is registered when loaded, so a write committing in the same cycle is not visible in that beat (old value); visible on later loads.
- Simultaneous AW and AR handshakes in one cycle are both accepted.
- regs_flat updates the cycle after the W handshake.

Test Plan:
- Single write ADDR=0x08, WDATA=0xDEADBEEF, WSTRB=4'hF, AWID=3 -> BID=3, BRESP=0, regs_flat[95:64]=0xDEADBEEF, wr_pulse[2] one cycle; then read ADDR=0x08 -> RDATA=0xDEADBEEF, RLAST=1, RVALID exactly 1 cycle after AR handshake.
- INCR write LEN=3 from index 14 (DEPTH=16), data 1,2,3,4 -> registers 14,15,0,1 = 1,2,3,4; INCR read LEN=3 from index 14 with RREADY toggling 1/0 -> 1,2,3,4 in order, data stable during stalls, RLAST only on beat 3.
- Byte strobes: reg5=0x11223344, write 0xAABBCCDD WSTRB=4'b0101 -> reg5=0x11BB33DD.
- FIXED write LEN=2, data 7,8,9 to index 4 -> reg4=9, wr_pulse[4] three times; BURST=WRAP write -> BRESP=2, registers unchanged; SIZE=0 read LEN=1 -> two beats RDATA=0, RRESP=2.
- WLAST on beat 1 of LEN=2 burst -> 3 beats accepted, BRESP=2; BREADY held low 5 cycles -> BVALID/BID/BRESP stable, AWREADY stays 0.
- Assert rstn low mid read burst (beat 1 of LEN=7) -> RVALID=0 immediately, all registers 0; after release, new read of index 0 -> RDATA=0, OKAY.
